// File: rtl/rom_pkg.sv
// Shared constants and FSM state type for the ROM read-side stream controller.
package rom_pkg;
    localparam int ROM_ADDR_W = 4;
    localparam int ROM_DATA_W = 8;
    localparam int ROM_LAT    = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rd_state_t;
endpackage

// File: rtl/rom_byte_fifo.sv
// Two-entry synchronous FIFO that buffers ROM bytes between the read pipe and the stream port.
module rom_byte_fifo
    import rom_pkg::*;
#(
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_empty,
    output logic [1:0]        o_count
);
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;
endmodule

// File: rtl/rom_stream_reader.sv
// Burst reader: walks a block of ROM addresses and streams the bytes on a valid/ready port.
module rom_stream_reader
    import rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_enable,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    rd_state_t         r_state;
    rd_state_t         w_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_accepted;
    logic              r_inflight;
    logic              w_rom_en;
    logic              w_pop;
    logic              w_empty;
    logic [1:0]        w_fifo_count;
    logic [2:0]        w_used;
    logic              w_credit;

    assign w_pop  = out_valid && out_ready;
    assign w_used = {1'b0, w_fifo_count} + {2'b00, r_inflight};
    // A slot freed by this cycle's pop can be refilled by the read issued now,
    // which keeps one byte per cycle flowing without ever exceeding two entries.
    assign w_credit = (w_used < 3'd2) || ((w_used == 3'd2) && w_pop);

    always_comb begin
        w_next   = r_state;
        w_rom_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (length == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                w_rom_en = w_credit && (r_issued != r_len);
                if (w_rom_en && ((r_issued + ONE) == r_len)) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && ((r_accepted + ONE) == r_len)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rom_en;
            if ((r_state == ST_IDLE) && start) begin
                r_base     <= base_addr;
                r_len      <= length;
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (w_rom_en) begin
                    r_issued <= r_issued + ONE;
                end
                if (w_pop) begin
                    r_accepted <= r_accepted + ONE;
                end
            end
        end
    end

    // Address arithmetic is ADDR_W bits wide, so the walk wraps past the top of the ROM.
    assign rom_addr   = r_base + r_issued[ADDR_W-1:0];
    assign rom_enable = w_rom_en;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign out_valid  = !w_empty;

    rom_byte_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_din   (rom_data),
        .i_pop   (w_pop),
        .o_head  (out_data),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );
endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader with a 16x8 ROM model holding mem[i] = 8'hA0 + i.
module tb_rom_stream_reader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] base_addr = '0;
    logic [4:0] length = '0;
    logic       busy;
    logic       done;
    logic [3:0] rom_addr;
    logic       rom_enable;
    logic [7:0] rom_data = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // monitor state
    bit         mon_en = 1'b0;
    logic [7:0] got[$];
    logic [3:0] addr_q[$];
    int         done_cnt, en_cnt, busy_cnt, first_valid_cyc, done_cyc;
    int         stall_err, credit_err;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    int         m_cnt = 0;
    int         m_infl = 0;

    typedef struct {
        logic [3:0] base;
        logic [4:0] len;
        bit         tog;
        int         restart_at;
        logic [7:0] first;
        logic [7:0] last;
        int         lat;
    } vec_t;
    vec_t vecs[7];

    rom_stream_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_enable (rom_enable),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_ff @(posedge clk) begin
        if (rom_enable) rom_data <= {4'hA, rom_addr};
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (busy) busy_cnt++;
            if (rom_enable) begin
                en_cnt++;
                addr_q.push_back(rom_addr);
            end
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
            if (rom_enable && (m_cnt + m_infl == 2) && !(out_valid && out_ready)) credit_err++;
            if (reset) begin
                m_cnt      = 0;
                m_infl     = 0;
                prev_stall = 1'b0;
            end else begin
                m_cnt      = m_cnt + m_infl - ((out_valid && out_ready) ? 1 : 0);
                m_infl     = rom_enable ? 1 : 0;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic clear_mon();
        got.delete();
        addr_q.delete();
        done_cnt        = 0;
        en_cnt          = 0;
        busy_cnt        = 0;
        first_valid_cyc = -1;
        done_cyc        = -1;
        stall_err       = 0;
        credit_err      = 0;
    endtask

    task automatic run_burst(input int idx, input vec_t v);
        int         n;
        int         start_cyc;
        logic [3:0] a;
        string      p;
        p = $sformatf("v%0d", idx);
        clear_mon();
        start_cyc = cyc;
        start     = 1'b1;
        base_addr = v.base;
        length    = v.len;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(done_cnt > 0 && !busy) && n < 300) begin
            if (n == v.restart_at) begin
                start     = 1'b1;
                base_addr = 4'd9;
                length    = 5'd3;
            end else begin
                start = 1'b0;
            end
            if (v.tog) out_ready = ~out_ready;
            step();
            n++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        check({p, "_timeout"}, (n < 300) ? 1 : 0, 1);
        check({p, "_count"}, got.size(), int'(v.len));
        for (int i = 0; i < got.size() && i < int'(v.len); i++) begin
            a = v.base + 4'(i);
            check($sformatf("%s_byte%0d", p, i), got[i], {4'hA, a});
        end
        if (v.len != 0 && got.size() == int'(v.len)) begin
            check({p, "_first"}, got[0], v.first);
            check({p, "_last"}, got[got.size()-1], v.last);
        end
        check({p, "_done_pulses"}, done_cnt, 1);
        check({p, "_rom_reads"}, en_cnt, int'(v.len));
        for (int i = 0; i < addr_q.size(); i++) begin
            a = v.base + 4'(i);
            check($sformatf("%s_addr%0d", p, i), addr_q[i], a);
        end
        check({p, "_busy_end"}, busy, 0);
        check({p, "_credit"}, credit_err, 0);
        if (v.tog) check({p, "_stall_stable"}, stall_err, 0);
        if (v.lat >= 0) begin
            check({p, "_latency"}, first_valid_cyc - start_cyc, v.lat);
        end else begin
            check({p, "_no_valid"}, first_valid_cyc, -1);
            check({p, "_busy_cycles"}, busy_cnt, 1);
            check({p, "_done_delay"}, done_cyc - start_cyc, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{base: 4'd0,  len: 5'd16, tog: 1'b0, restart_at: -1, first: 8'hA0, last: 8'hAF, lat: 3};
        vecs[1] = '{base: 4'd14, len: 5'd4,  tog: 1'b0, restart_at: -1, first: 8'hAE, last: 8'hA1, lat: 3};
        vecs[2] = '{base: 4'd0,  len: 5'd8,  tog: 1'b1, restart_at: -1, first: 8'hA0, last: 8'hA7, lat: 3};
        vecs[3] = '{base: 4'd0,  len: 5'd0,  tog: 1'b0, restart_at: -1, first: 8'h00, last: 8'h00, lat: -1};
        vecs[4] = '{base: 4'd0,  len: 5'd6,  tog: 1'b0, restart_at: 2,  first: 8'hA0, last: 8'hA5, lat: 3};
        vecs[5] = '{base: 4'd15, len: 5'd1,  tog: 1'b0, restart_at: -1, first: 8'hAF, last: 8'hAF, lat: 3};
        vecs[6] = '{base: 4'd7,  len: 5'd16, tog: 1'b0, restart_at: -1, first: 8'hA7, last: 8'hA6, lat: 3};

        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_enable", rom_enable, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_burst(i, vecs[i]);
            step();
        end

        // reset in the middle of a stalled burst
        clear_mon();
        start     = 1'b1;
        base_addr = 4'd0;
        length    = 5'd10;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (got.size() < 3 && n < 50) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        check("mid_rst_reach3", (n < 50) ? 1 : 0, 1);
        step();
        step();
        check("mid_rst_stalled_valid", out_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rom_enable", rom_enable, 0);
        check("mid_rst_out_data", out_data, 0);
        step();
        step();
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_accepted", got.size(), 3);
        if (got.size() == 3) begin
            check("mid_rst_b0", got[0], 8'hA0);
            check("mid_rst_b2", got[2], 8'hA2);
        end
        run_burst(7, '{base: 4'd5, len: 5'd2, tog: 1'b0, restart_at: -1, first: 8'hA5, last: 8'hA6, lat: 3});

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
